// File: rtl/object_engine.sv
// object_engine: game-state engine for a side-scrolling runner.
// It moves one player (slot 0) and up to `DATACOUNT-1 enemies on a
// divided game tick. Enemies spawn at pseudo-random intervals taken
// from a Galois LFSR.
// Ports:
//   clk       system clock; all state changes on the rising edge
//   reset     asynchronous, active-low
//   start     level; IDLE->RUN, and OVER->IDLE
//   jump      level; jump request, sampled on game ticks in RUN
//   collide   collision flag from downstream logic; RUN->OVER
//   gamedata  packed object table; slot i is at [i*`DATALEN +: `DATALEN]
//   state     0=IDLE, 1=RUN, 2=OVER
//   score     enemies passed this game (saturating)

`ifndef OBJECT_ENGINE_DEFS
`define OBJECT_ENGINE_DEFS
`define DATALEN       32
`define DATACOUNT     8
`define DATATYPESTART 0
`define DATATYPELEN   4
`define DATAXSTART    4
`define DATAXLEN      8
`define DATAYSTART    12
`define DATAYLEN      8
`define DATAWSTART    20
`define DATAWLEN      6
`define DATAHSTART    26
`define DATAHLEN      6
`define EMPTYTYPE     4'd0
`define PLAYERTYPE    4'd1
`define ENEMYTYPE     4'd2
`define PLAYERW       6'd8
`define PLAYERH       6'd12
`define ENEMYW        6'd8
`define ENEMYH        6'd8
`endif

module object_engine #(
   parameter int unsigned TICKDIV  = 100000,
   parameter int unsigned PLAYERX  = 16,
   parameter int unsigned GROUNDY  = 0,
   parameter int unsigned JUMPV    = 12,
   parameter int unsigned GRAVITY  = 1,
   parameter int unsigned SPAWNX   = 150,
   parameter int unsigned SCROLL   = 2,
   parameter int unsigned SPAWNMIN = 20
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic                              jump,
   input  logic                              collide,
   output logic [`DATALEN*`DATACOUNT-1:0]    gamedata,
   output logic [1:0]                        state,
   output logic [15:0]                       score
);

   localparam int          NSLOT = `DATACOUNT;
   localparam int unsigned XW    = `DATAXLEN;
   localparam int unsigned YW    = `DATAYLEN;
   localparam int unsigned DIVW  = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
   localparam int unsigned CNTW  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   state_t                 cur_state, nxt_state;
   logic [DIVW-1:0]        div_q, div_d;
   logic [CNTW-1:0]        cnt_q, cnt_d;
   logic [15:0]            lfsr_q, lfsr_d;
   logic [15:0]            score_q, score_d;
   logic [YW-1:0]          py_q, py_d;
   logic signed [7:0]      vy_q, vy_d;
   logic [XW-1:0]          ex_q [1:NSLOT-1];
   logic [XW-1:0]          ex_d [1:NSLOT-1];
   logic [NSLOT-1:1]       act_q, act_d;

   logic                   tick;
   logic                   grounded;
   logic                   found;
   logic signed [YW:0]     vy_ext;
   logic signed [YW:0]     ysum;
   logic [XW:0]            xdiff;
   logic [3:0]             npass;
   logic [16:0]            score_sum;

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_state <= ST_IDLE;
         div_q     <= '0;
         cnt_q     <= CNTW'(SPAWNMIN);
         lfsr_q    <= 16'hACE1;
         score_q   <= '0;
         py_q      <= YW'(GROUNDY);
         vy_q      <= '0;
         act_q     <= '0;
         for (int i = 1; i < NSLOT; i++) begin
            ex_q[i] <= '0;
         end
      end else begin
         cur_state <= nxt_state;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         lfsr_q    <= lfsr_d;
         score_q   <= score_d;
         py_q      <= py_d;
         vy_q      <= vy_d;
         act_q     <= act_d;
         for (int i = 1; i < NSLOT; i++) begin
            ex_q[i] <= ex_d[i];
         end
      end
   end

   // Next-state and game update logic
   always_comb begin
      nxt_state = cur_state;
      div_d     = div_q;
      cnt_d     = cnt_q;
      score_d   = score_q;
      py_d      = py_q;
      vy_d      = vy_q;
      act_d     = act_q;
      ex_d      = ex_q;
      npass     = '0;
      found     = 1'b0;
      score_sum = '0;
      xdiff     = '0;

      // LFSR free-runs in every state
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

      tick     = (cur_state == ST_RUN) && (div_q == DIVW'(TICKDIV - 1));
      // Standing still on the ground; a fresh jump leaves y at ground with vy>0
      grounded = (py_q == YW'(GROUNDY)) && (vy_q == 8'sd0);
      vy_ext   = {{(YW + 1 - 8){vy_q[7]}}, vy_q};
      ysum     = $signed({1'b0, py_q}) + vy_ext;

      case (cur_state)
         ST_IDLE: begin
            if (start) begin
               nxt_state = ST_RUN;
               score_d   = '0;
               div_d     = '0;
               cnt_d     = CNTW'(SPAWNMIN) + CNTW'(lfsr_q[3:0]);
            end
         end

         ST_RUN: begin
            if (collide) begin
               // Freeze the table as-is; a coinciding tick is dropped
               nxt_state = ST_OVER;
            end else if (!tick) begin
               div_d = div_q + DIVW'(1);
            end else begin
               div_d = '0;

               // Player vertical motion
               if (grounded) begin
                  if (jump) begin
                     vy_d = 8'(JUMPV);
                  end
               end else if (ysum <= $signed((YW + 1)'(GROUNDY))) begin
                  py_d = YW'(GROUNDY);
                  vy_d = '0;
               end else begin
                  py_d = ysum[YW-1:0];
                  vy_d = vy_q - $signed(8'(GRAVITY));
               end

               // Enemy scroll; a borrow out of x-SCROLL means it left the screen
               for (int i = 1; i < NSLOT; i++) begin
                  if (act_q[i]) begin
                     xdiff = {1'b0, ex_q[i]} - (XW + 1)'(SCROLL);
                     if (xdiff[XW]) begin
                        act_d[i] = 1'b0;
                        ex_d[i]  = '0;
                        npass    = npass + 4'd1;
                     end else begin
                        ex_d[i] = xdiff[XW-1:0];
                     end
                  end
               end

               score_sum = {1'b0, score_q} + 17'(npass);
               score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];

               // Spawn into the lowest slot that was empty before this tick
               if (cnt_q <= CNTW'(1)) begin
                  cnt_d = CNTW'(SPAWNMIN) + CNTW'(lfsr_q[3:0]);
                  for (int i = 1; i < NSLOT; i++) begin
                     if (!found && !act_q[i]) begin
                        found    = 1'b1;
                        act_d[i] = 1'b1;
                        ex_d[i]  = XW'(SPAWNX);
                     end
                  end
               end else begin
                  cnt_d = cnt_q - CNTW'(1);
               end
            end
         end

         ST_OVER: begin
            if (start) begin
               nxt_state = ST_IDLE;
               py_d      = YW'(GROUNDY);
               vy_d      = '0;
               act_d     = '0;
               for (int i = 1; i < NSLOT; i++) begin
                  ex_d[i] = '0;
               end
            end
         end

         default: nxt_state = ST_IDLE;
      endcase
   end

   // Pack the object table from registered state
   always_comb begin
      gamedata = '0;
      gamedata[`DATATYPESTART +: `DATATYPELEN] = `PLAYERTYPE;
      gamedata[`DATAXSTART    +: `DATAXLEN]    = XW'(PLAYERX);
      gamedata[`DATAYSTART    +: `DATAYLEN]    = py_q;
      gamedata[`DATAWSTART    +: `DATAWLEN]    = `PLAYERW;
      gamedata[`DATAHSTART    +: `DATAHLEN]    = `PLAYERH;
      for (int i = 1; i < NSLOT; i++) begin
         if (act_q[i]) begin
            gamedata[i*`DATALEN + `DATATYPESTART +: `DATATYPELEN] = `ENEMYTYPE;
            gamedata[i*`DATALEN + `DATAXSTART    +: `DATAXLEN]    = ex_q[i];
            gamedata[i*`DATALEN + `DATAYSTART    +: `DATAYLEN]    = YW'(GROUNDY);
            gamedata[i*`DATALEN + `DATAWSTART    +: `DATAWLEN]    = `ENEMYW;
            gamedata[i*`DATALEN + `DATAHSTART    +: `DATAHLEN]    = `ENEMYH;
         end else begin
            gamedata[i*`DATALEN + `DATATYPESTART +: `DATATYPELEN] = `EMPTYTYPE;
         end
      end
   end

   assign state = cur_state;
   assign score = score_q;

endmodule
